// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and constants for the reset sequencer.
//   state_t    : sequencer FSM states
//   LOSS_CNT_W : width of the saturating lock-loss counter
//   sat_inc    : saturating increment for the lock-loss counter
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int LOSS_CNT_W = 8;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == {LOSS_CNT_W{1'b1}}) ? v : v + LOSS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Multi-flop synchroniser for a single asynchronous level signal. The chain
// resets to 0, so a lock indication is never seen as present right after
// reset.
// Ports:
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset (clears the chain)
//   d_i     : asynchronous input level
//   q_o     : synchronised level, SYNC_STAGES cycles of latency
// ---------------------------------------------------------------------------
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctl
// Reset sequencer behind the PLL: filters the PLL lock, holds all downstream
// resets for a minimum time, then releases them one by one with a fixed gap.
// Lock loss or a software request drops every output at once.
// Ports:
//   clk_in            : system clock
//   rst_n_in          : asynchronous active-low reset
//   pll_locked_in     : PLL lock, asynchronous to clk_in
//   sw_rst_in         : synchronous level software reset request
//   rst_n_out         : sequenced active-low resets, bit 0 released first
//   rst_done_out      : all outputs released
//   lock_loss_cnt_out : saturating count of lock losses
// ---------------------------------------------------------------------------
module rst_seq_ctl
    import rst_seq_pkg::*;
#(
    parameter int N_RST       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILT   = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  pll_locked_in,
    input  logic                  sw_rst_in,
    output logic [N_RST-1:0]      rst_n_out,
    output logic                  rst_done_out,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt_out
);

    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);

    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(STAGE_GAP);

    // Bit 0 is already released when RELEASE starts, so shifting the
    // released pattern up by one frees exactly the next bit in index order.
    function automatic logic [N_RST-1:0] release_next(input logic [N_RST-1:0] cur);
        logic [N_RST-1:0] nxt;
        nxt    = cur;
        nxt[0] = 1'b1;
        for (int i = 1; i < N_RST; i++) begin
            nxt[i] = cur[i-1];
        end
        return nxt;
    endfunction

    logic                  locked_s;
    state_t                state_q, state_d;
    logic [FILT_W-1:0]     filt_cnt_q, filt_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [N_RST-1:0]      rst_n_q, rst_n_d;
    logic                  done_q, done_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    logic [FILT_W-1:0]     filt_inc;
    logic [HOLD_W-1:0]     hold_inc;
    logic [GAP_W-1:0]      gap_inc;
    logic                  filt_hit, hold_hit, gap_hit;
    logic                  lock_lost, sw_evt, all_rel;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .d_i     (pll_locked_in),
        .q_o     (locked_s)
    );

    // The counters stop one short of the parameter; the "hit" compares the
    // incremented value so the transition lands on the counting edge itself.
    assign filt_inc = filt_cnt_q + FILT_W'(1);
    assign hold_inc = hold_cnt_q + HOLD_W'(1);
    assign gap_inc  = gap_cnt_q + GAP_W'(1);
    assign filt_hit = (filt_inc == FILT_MAX);
    assign hold_hit = (hold_inc == HOLD_MAX);
    assign gap_hit  = (gap_inc == GAP_MAX);

    // Lock loss outranks the software request; both only matter after lock.
    assign lock_lost = (state_q != WAIT_LOCK) && !locked_s;
    assign sw_evt    = (state_q != WAIT_LOCK) && locked_s && sw_rst_in;
    assign all_rel   = rst_n_q[N_RST-1];

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (lock_lost) begin
            state_d = WAIT_LOCK;
        end else if (sw_evt) begin
            state_d = HOLD;
        end else begin
            case (state_q)
                WAIT_LOCK: if (locked_s && filt_hit) state_d = HOLD;
                HOLD:      if (hold_hit)             state_d = RELEASE;
                RELEASE:   if (all_rel)              state_d = RUN;
                RUN:       state_d = RUN;
                default:   state_d = WAIT_LOCK;
            endcase
        end
    end

    // Output and counter next-state logic
    always_comb begin
        filt_cnt_d = '0;
        hold_cnt_d = '0;
        gap_cnt_d  = '0;
        rst_n_d    = rst_n_q;
        loss_cnt_d = loss_cnt_q;
        if (lock_lost) begin
            rst_n_d    = '0;
            loss_cnt_d = sat_inc(loss_cnt_q);
        end else if (sw_evt) begin
            rst_n_d = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    rst_n_d = '0;
                    if (locked_s && !filt_hit) filt_cnt_d = filt_inc;
                end
                HOLD: begin
                    rst_n_d = '0;
                    if (hold_hit) rst_n_d[0] = 1'b1;
                    else          hold_cnt_d = hold_inc;
                end
                RELEASE: begin
                    if (!all_rel) begin
                        if (gap_hit) rst_n_d   = release_next(rst_n_q);
                        else         gap_cnt_d = gap_inc;
                    end
                end
                default: ;
            endcase
        end
        // Done is registered on the same edge that enters RUN.
        done_d = (state_d == RUN);
    end

    // Counter and output registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            filt_cnt_q <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rst_n_q    <= '0;
            done_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rst_n_q    <= rst_n_d;
            done_q     <= done_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign rst_n_out         = rst_n_q;
    assign rst_done_out      = done_q;
    assign lock_loss_cnt_out = loss_cnt_q;

endmodule

// File: tb/tb_rst_seq_ctl.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_ctl
// Directed bench for rst_seq_ctl with default parameters. Release timing is
// expressed relative to the first edge that samples pll_locked_in high:
// bit0 at 26, then every 8 edges, done at 51.
// ---------------------------------------------------------------------------
module tb_rst_seq_ctl;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       pll_locked_in;
    logic       sw_rst_in;
    logic [3:0] rst_n_out;
    logic       rst_done_out;
    logic [7:0] lock_loss_cnt_out;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_loss = 0;

    rst_seq_ctl dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .pll_locked_in     (pll_locked_in),
        .sw_rst_in         (sw_rst_in),
        .rst_n_out         (rst_n_out),
        .rst_done_out      (rst_done_out),
        .lock_loss_cnt_out (lock_loss_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Expected rst_n_out at relative edge r after lock is first sampled.
    function automatic logic [3:0] exp_vec(input int r);
        int k;
        if (r < 26) k = 0;
        else begin
            k = 1 + (r - 26) / 8;
            if (k > 4) k = 4;
        end
        return 4'((1 << k) - 1);
    endfunction

    task automatic seq_check(input string tag, input int r_first, input int r_last);
        for (int r = r_first; r <= r_last; r++) begin
            step();
            chk($sformatf("%s rst_n r%0d", tag, r), {28'd0, rst_n_out}, {28'd0, exp_vec(r)});
            chk($sformatf("%s done r%0d", tag, r), {31'd0, rst_done_out}, {31'd0, (r >= 51)});
        end
        chk($sformatf("%s loss", tag), {24'd0, lock_loss_cnt_out}, exp_loss);
    endtask

    task automatic do_reset(input string tag);
        pll_locked_in = 1'b0;
        sw_rst_in     = 1'b0;
        rst_n_in      = 1'b0;
        step();
        step();
        chk({tag, " rst_n"}, {28'd0, rst_n_out}, 32'h0);
        chk({tag, " loss"}, {24'd0, lock_loss_cnt_out}, 32'h0);
        rst_n_in = 1'b1;
        exp_loss = 0;
    endtask

    initial begin
        // Async reset before any clock edge
        rst_n_in      = 1'b1;
        pll_locked_in = 1'b0;
        sw_rst_in     = 1'b0;
        #1 rst_n_in = 1'b0;
        #2;
        chk("por rst_n", {28'd0, rst_n_out}, 32'h0);
        chk("por done", {31'd0, rst_done_out}, 32'h0);
        chk("por loss", {24'd0, lock_loss_cnt_out}, 32'h0);
        step();
        step();
        rst_n_in = 1'b1;

        // Power-up: lock appears 5 cycles after reset release
        repeat (5) step();
        chk("pwr idle", {28'd0, rst_n_out}, 32'h0);
        pll_locked_in = 1'b1;
        seq_check("pwr", 1, 55);

        // Lock glitch in WAIT_LOCK: 5 high, 3 low, then stable
        do_reset("glitch rst");
        pll_locked_in = 1'b1;
        repeat (5) step();
        pll_locked_in = 1'b0;
        repeat (3) step();
        chk("glitch none", {28'd0, rst_n_out}, 32'h0);
        pll_locked_in = 1'b1;
        seq_check("glitch", 1, 53);

        // One-cycle lock drop in RUN
        pll_locked_in = 1'b0;
        step();
        chk("loss e1 rst_n", {28'd0, rst_n_out}, 32'hF);
        pll_locked_in = 1'b1;
        step();
        chk("loss e2 rst_n", {28'd0, rst_n_out}, 32'hF);
        chk("loss e2 done", {31'd0, rst_done_out}, 32'h1);
        step();
        chk("loss e3 rst_n", {28'd0, rst_n_out}, 32'h0);
        chk("loss e3 done", {31'd0, rst_done_out}, 32'h0);
        chk("loss e3 cnt", {24'd0, lock_loss_cnt_out}, 32'h1);
        exp_loss = 1;
        seq_check("reseq", 3, 53);

        // Software reset for 4 cycles in RUN
        sw_rst_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("sw e%0d rst_n", i), {28'd0, rst_n_out}, 32'h0);
            chk($sformatf("sw e%0d done", i), {31'd0, rst_done_out}, 32'h0);
        end
        sw_rst_in = 1'b0;
        seq_check("swrst", 11, 55);

        // Lock loss and sw_rst_in together during RELEASE
        do_reset("sim rst");
        pll_locked_in = 1'b1;
        seq_check("simpre", 1, 30);
        pll_locked_in = 1'b0;
        step();
        chk("sim e1 rst_n", {28'd0, rst_n_out}, 32'h1);
        step();
        chk("sim e2 rst_n", {28'd0, rst_n_out}, 32'h1);
        sw_rst_in = 1'b1;
        step();
        chk("sim e3 rst_n", {28'd0, rst_n_out}, 32'h0);
        chk("sim e3 cnt", {24'd0, lock_loss_cnt_out}, 32'h1);
        exp_loss = 1;
        sw_rst_in     = 1'b0;
        pll_locked_in = 1'b1;
        step();
        chk("sim wait_lock cnt", {24'd0, lock_loss_cnt_out}, 32'h1);
        seq_check("simreseq", 2, 52);

        // Lock-loss counter saturation
        do_reset("sat rst");
        for (int i = 1; i <= 260; i++) begin
            pll_locked_in = 1'b1;
            repeat (10) step();
            pll_locked_in = 1'b0;
            repeat (3) step();
            chk($sformatf("sat cnt %0d", i), {24'd0, lock_loss_cnt_out}, (i > 255) ? 255 : i);
        end
        exp_loss = 255;

        // Async reset in the middle of RELEASE
        pll_locked_in = 1'b1;
        seq_check("postsat", 1, 35);
        #2 rst_n_in = 1'b0;
        #1;
        chk("async rst_n", {28'd0, rst_n_out}, 32'h0);
        chk("async done", {31'd0, rst_done_out}, 32'h0);
        chk("async loss", {24'd0, lock_loss_cnt_out}, 32'h0);
        rst_n_in = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctl.md
# rst_seq_ctl

Parametrised reset sequencer for the system clock domain. It sits directly behind the PLL and global clock buffer. It qualifies the PLL lock signal, enforces a minimum reset hold time, and releases N downstream reset domains one after another with a programmable gap. It also re-enters reset on lock loss or on a software request, and counts lock-loss events.

## Interface
- N_RST, 4: number of sequenced reset outputs (≥1)
- SYNC_STAGES, 2: synchroniser depth for pll_locked_in (≥2)
- LOCK_FILT, 8: consecutive synchronised-high cycles required to accept lock (≥1)
- HOLD_CYCLES, 16: minimum all-asserted hold after lock accepted (≥1)
- STAGE_GAP, 8: cycles between successive output releases (≥1)

Ports:
- clk_in  in  1  system clock; one clock domain only
- rst_n_in  in  1  asynchronous, active-low reset
- pll_locked_in  in  1  PLL locked, asynchronous to clk_in
- sw_rst_in  in  1  synchronous, level-sensitive software reset request
- rst_n_out  out  N_RST  sequenced active-low resets; bit 0 released first
- rst_done_out  out  1  high when all outputs are released
- lock_loss_cnt_out  out  8  saturating count of lock losses after first lock

## Operation
- pll_locked_in passes through a SYNC_STAGES flop chain to give locked_s; no other input is synchronised.
- FSM states are WAIT_LOCK, HOLD, RELEASE and RUN. Reset state is WAIT_LOCK.
- WAIT_LOCK:
  - filt_cnt increments while locked_s=1 and clears when locked_s=0.
  - When filt_cnt reaches LOCK_FILT, go to HOLD.
- HOLD:
  - hold_cnt counts to HOLD_CYCLES, then the FSM goes to RELEASE.
  - On that same edge, rst_n_out[0] is set to 1.
- RELEASE:
  - gap_cnt counts STAGE_GAP cycles, then the next bit is released and gap_cnt clears.
  - Once bit N_RST-1 is released, go to RUN on the next edge. rst_done_out is registered 1 in RUN.
- Lock loss: locked_s=0 in HOLD, RELEASE or RUN means that on the next edge:
  - all rst_n_out=0 and rst_done_out=0;
  - all counters clear and the FSM goes to WAIT_LOCK;
  - lock_loss_cnt increments and saturates at 255.
- Software reset: sw_rst_in=1 with locked_s=1 in HOLD, RELEASE or RUN means that on the next edge all outputs go to 0 and the FSM enters HOLD with hold_cnt=0. While sw_rst_in stays high, hold_cnt is held at 0.
- Simultaneous events: lock loss takes priority over sw_rst_in. sw_rst_in is ignored in WAIT_LOCK.
- rst_n_out bits release strictly in index order and are never released out of order. Once set, a bit stays 1 until a reset, lock-loss or software-reset event, which clears all bits together.
- Counter widths are $clog2(param+1); compare against the parameter value using equality.
- N_RST=1: RELEASE lasts zero gap cycles, so RUN follows HOLD completion by one edge.

## Timing
- Asynchronous reset (rst_n_in=0) drives, immediately:
  - rst_n_out=0, rst_done_out=0, lock_loss_cnt_out=0;
  - the synchroniser to 0 and the FSM to WAIT_LOCK.
- All outputs are registered; there are no combinational input-to-output paths.
- Let edge 1 be the first edge sampling pll_locked_in=1, held stable. Release times are:
  - rst_n_out[0] rises at edge L0 = SYNC_STAGES + LOCK_FILT + HOLD_CYCLES;
  - rst_n_out[i] rises at edge L0 + i·STAGE_GAP;
  - rst_done_out rises at edge L0 + (N_RST-1)·STAGE_GAP + 1.
- Lock-loss response: all outputs are low at edge SYNC_STAGES+1, counting the first edge sampling pll_locked_in=0 as edge 1.
- Software-reset response: the first edge sampling sw_rst_in=1 clears all outputs. rst_n_out[0] re-rises HOLD_CYCLES edges after the first edge sampling sw_rst_in=0.
- A lock glitch shorter than LOCK_FILT cycles in WAIT_LOCK restarts filtering and releases nothing.

## Structure
- Package rst_seq_pkg holds:
  - the state_t enum (WAIT_LOCK, HOLD, RELEASE, RUN);
  - the localparam LOSS_CNT_W=8.
- Sub-module bit_sync(SYNC_STAGES) provides the reset-to-0 flop chain for pll_locked_in.
- The FSM, counters and output registers live in rst_seq_ctl.

## Test plan
All scenarios use default parameters.
- Power-up: raise pll_locked_in 5 cycles after rst_n_in deasserts.
  - rst_n_out goes 0001 at edge 26, 0011 at 34, 0111 at 42, 1111 at 50.
  - rst_done_out=1 at edge 51; lock_loss_cnt_out=0.
- Lock glitch: pll_locked_in high for 5 cycles, low for 3, then stable.
  - No release occurs during the glitch; timing restarts, with rst_n_out[0] at edge 26 after the final rise.
- Lock loss in RUN: drop pll_locked_in for 1 cycle.
  - All rst_n_out=0 and rst_done_out=0 at edge 3; lock_loss_cnt_out=1.
  - A full re-sequence follows.
- Software reset: sw_rst_in=1 for 4 cycles in RUN.
  - Outputs go 0000 on the first sampling edge.
  - rst_n_out[0] re-rises 16 edges after sw_rst_in falls; lock_loss_cnt_out is unchanged.
- Simultaneous events: sw_rst_in=1 and lock loss together during RELEASE.
  - FSM goes to WAIT_LOCK, not HOLD; lock_loss_cnt_out increments.
- Saturation and async reset:
  - Force 260 lock losses: lock_loss_cnt_out=255.
  - Assert rst_n_in mid-RELEASE: all outputs are 0 without waiting for a clock edge.
